// File: rtl/ahb_default_slave_cfg.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_cfg
//
// Configurable AHB default slave.  Answers every transfer routed to an
// unmapped region, either with a two-cycle ERROR response or with an OKAY
// read-as-zero / write-ignored response, after WAIT_STATES wait cycles.
// For debug it captures the address/direction of the last erroring transfer,
// counts ERROR responses (saturating) and pulses ERR_IRQ once per error.
//
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HREADY   AHB address phase / bus ready
//   HREADYOUT, HRESP, HRDATA              AHB data-phase response
//   ERR_IRQ        one-cycle pulse while the first ERROR cycle is presented
//   FAULT_ADDR     HADDR of the most recent ERROR-responded transfer
//   FAULT_WRITE    HWRITE of that transfer
//   ERR_COUNT      saturating count of ERROR responses
//   CNT_CLR        synchronous clear of ERR_COUNT
// ---------------------------------------------------------------------------
module ahb_default_slave_cfg #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RESP_MODE   = 0,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  ERR_IRQ,
    output logic [ADDR_WIDTH-1:0] FAULT_ADDR,
    output logic                  FAULT_WRITE,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    input  logic                  CNT_CLR
);

    // The wait counter is 4 bits wide; larger settings cannot be honoured.
    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("ahb_default_slave_cfg: WAIT_STATES=%0d exceeds 15", WAIT_STATES);
    end
    if (RESP_MODE > 1) begin : g_bad_resp_mode
        $error("ahb_default_slave_cfg: RESP_MODE=%0d must be 0 or 1", RESP_MODE);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
    logic                    fault_write_q, fault_write_d;
    logic                    accept;
    logic                    take;
    logic                    err_entry;
    logic                    unused_ok;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign unused_ok = HTRANS[0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            wcnt_q        <= '0;
            cnt_q         <= '0;
            fault_addr_q  <= '0;
            fault_write_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            cnt_q         <= cnt_d;
            fault_addr_q  <= fault_addr_d;
            fault_write_q <= fault_write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        take    = 1'b0;
        unique case (state_q)
            // States whose data phase completes this cycle may take a new
            // address phase, which keeps pipelined transfers gap-free.
            S_IDLE, S_ERR2, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    take = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else if (RESP_MODE == 0) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = (RESP_MODE == 0) ? S_ERR1 : S_DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // Error count advances on the edge that enters ERR1; a coincident clear
    // still records that new error.
    assign err_entry = (state_d == S_ERR1);

    always_comb begin
        cnt_d = cnt_q;
        if (CNT_CLR) begin
            cnt_d = err_entry ? CNT_WIDTH'(1) : '0;
        end else if (err_entry && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        fault_addr_d  = fault_addr_q;
        fault_write_d = fault_write_q;
        if (take && (RESP_MODE == 0)) begin
            fault_addr_d  = HADDR;
            fault_write_d = HWRITE;
        end
    end

    assign HREADYOUT   = (state_q inside {S_IDLE, S_ERR2, S_DONE});
    assign HRESP       = {1'b0, (state_q inside {S_ERR1, S_ERR2})};
    assign HRDATA      = '0;
    assign ERR_IRQ     = (state_q == S_ERR1);
    assign FAULT_ADDR  = fault_addr_q;
    assign FAULT_WRITE = fault_write_q;
    assign ERR_COUNT   = cnt_q;

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// ---------------------------------------------------------------------------
// tb_ahb_default_slave_cfg
//
// Six differently configured instances share one address bus; each has its
// own HSEL bit and its HREADY tied to its own HREADYOUT.  A transfer-level
// model predicts every output from the transfer phase index and the latency
// rules; hand-computed literals pin the model at key points.
// ---------------------------------------------------------------------------
module tb_ahb_default_slave_cfg;

    localparam int NDUT = 6;

    function automatic int unsigned ws_of(int i);
        case (i)
            1:       return 3;
            2:       return 2;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned rm_of(int i);
        return (i == 2 || i == 5) ? 1 : 0;
    endfunction

    function automatic int unsigned cw_of(int i);
        return (i == 3) ? 2 : 8;
    endfunction

    // Cycles from accept to data-phase completion.
    function automatic int unsigned lat_of(int i);
        if (rm_of(i) == 0) return ws_of(i) + 2;
        return (ws_of(i) == 0) ? 1 : ws_of(i) + 1;
    endfunction

    logic              HCLK;
    logic              HRESETn;
    logic [NDUT-1:0]   hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic              cnt_clr;

    logic [NDUT-1:0]   d_rdy;
    logic [1:0]        d_resp  [NDUT];
    logic [31:0]       d_rdata [NDUT];
    logic [NDUT-1:0]   d_irq;
    logic [31:0]       d_fa    [NDUT];
    logic [NDUT-1:0]   d_fw;
    logic [31:0]       d_cnt   [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        logic [cw_of(gi)-1:0] cnt_w;
        ahb_default_slave_cfg #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .WAIT_STATES (ws_of(gi)),
            .RESP_MODE   (rm_of(gi)),
            .CNT_WIDTH   (cw_of(gi))
        ) u_dut (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .HSEL        (hsel[gi]),
            .HADDR       (haddr),
            .HTRANS      (htrans),
            .HWRITE      (hwrite),
            .HREADY      (d_rdy[gi]),
            .HREADYOUT   (d_rdy[gi]),
            .HRESP       (d_resp[gi]),
            .HRDATA      (d_rdata[gi]),
            .ERR_IRQ     (d_irq[gi]),
            .FAULT_ADDR  (d_fa[gi]),
            .FAULT_WRITE (d_fw[gi]),
            .ERR_COUNT   (cnt_w),
            .CNT_CLR     (cnt_clr)
        );
        assign d_cnt[gi] = 32'(cnt_w);
    end

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // ---------------- transfer-level model ----------------
    // mk = cycle index of the current data phase (0 = none in flight).
    int unsigned mk   [NDUT];
    int unsigned mcnt [NDUT];
    logic [31:0] mfa  [NDUT];
    logic        mfw  [NDUT];

    function automatic bit m_rdy(int i);
        return (mk[i] == 0) || (mk[i] == lat_of(i));
    endfunction

    function automatic bit m_err(int i);
        return (rm_of(i) == 0) && (mk[i] != 0) && (mk[i] + 1 >= lat_of(i));
    endfunction

    function automatic bit m_irq(int i);
        return (rm_of(i) == 0) && (mk[i] != 0) && (mk[i] + 1 == lat_of(i));
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin : model
        bit          acc;
        bit          inc;
        int unsigned nk;
        int unsigned maxc;
        if (!HRESETn) begin
            for (int i = 0; i < NDUT; i++) begin
                mk[i]   <= 0;
                mcnt[i] <= 0;
                mfa[i]  <= '0;
                mfw[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                acc = hsel[i] && htrans[1] && m_rdy(i);
                if (acc)                                nk = 1;
                else if (mk[i] != 0 && mk[i] < lat_of(i)) nk = mk[i] + 1;
                else                                    nk = 0;
                inc  = (rm_of(i) == 0) && (nk != 0) && (nk + 1 == lat_of(i));
                maxc = (32'd1 << cw_of(i)) - 1;
                if (cnt_clr)                       mcnt[i] <= inc ? 1 : 0;
                else if (inc && mcnt[i] < maxc)    mcnt[i] <= mcnt[i] + 1;
                if (acc && rm_of(i) == 0) begin
                    mfa[i] <= haddr;
                    mfw[i] <= hwrite;
                end
                mk[i] <= nk;
            end
        end
    end

    // ---------------- literal expectations ----------------
    typedef enum int { F_RDY, F_RESP, F_RDATA, F_IRQ, F_FA, F_FW, F_CNT } fld_e;
    typedef struct {
        string       name;
        int          inst;
        fld_e        fld;
        logic [31:0] exp;
    } lit_t;

    lit_t lit_q[$];
    int   lit_rd;

    task automatic lit(int i, string nm, fld_e f, logic [31:0] e);
        lit_t t;
        t.name = nm;
        t.inst = i;
        t.fld  = f;
        t.exp  = e;
        lit_q.push_back(t);
    endtask

    function automatic logic [31:0] act_of(int i, fld_e f);
        case (f)
            F_RDY:   return 32'(d_rdy[i]);
            F_RESP:  return 32'(d_resp[i]);
            F_RDATA: return d_rdata[i];
            F_IRQ:   return 32'(d_irq[i]);
            F_FA:    return d_fa[i];
            F_FW:    return 32'(d_fw[i]);
            default: return d_cnt[i];
        endcase
    endfunction

    // ---------------- compare process ----------------
    int n_vec;
    int n_err;

    task automatic cmp(int i, string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        #2;
        for (int i = 0; i < NDUT; i++) begin
            cmp(i, "hreadyout",   32'(d_rdy[i]),  32'(m_rdy(i)));
            cmp(i, "hresp",       32'(d_resp[i]), 32'(m_err(i)));
            cmp(i, "hrdata",      d_rdata[i],     32'h0);
            cmp(i, "err_irq",     32'(d_irq[i]),  32'(m_irq(i)));
            cmp(i, "fault_addr",  d_fa[i],        mfa[i]);
            cmp(i, "fault_write", 32'(d_fw[i]),   32'(mfw[i]));
            cmp(i, "err_count",   d_cnt[i],       mcnt[i]);
        end
        while (lit_rd < lit_q.size()) begin
            cmp(lit_q[lit_rd].inst, lit_q[lit_rd].name,
                act_of(lit_q[lit_rd].inst, lit_q[lit_rd].fld), lit_q[lit_rd].exp);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge; returns at the falling edge after
    // the rising edge that accepted the transfer.
    task automatic issue(int i, logic [31:0] a, logic w);
        int n;
        hsel   = '0;
        hsel[i] = 1'b1;
        haddr  = a;
        hwrite = w;
        htrans = 2'b10;
        n = 0;
        while (!d_rdy[i] && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 50) lit(i, "issue_timeout", F_RDY, 32'h2);
        @(negedge HCLK);
        hsel   = '0;
        htrans = 2'b00;
    endtask

    initial begin
        HRESETn = 1'b0;
        hsel    = '0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        cnt_clr = 1'b0;
        n_vec   = 0;
        n_err   = 0;
        lit_rd  = 0;

        @(negedge HCLK);
        lit(0, "rst_rdy",  F_RDY,  1);
        lit(0, "rst_resp", F_RESP, 0);
        lit(0, "rst_cnt",  F_CNT,  0);
        lit(0, "rst_fa",   F_FA,   0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Zero-wait ERROR read.
        issue(0, 32'h4000_1000, 1'b0);
        lit(0, "t1_err1_rdy",  F_RDY,  0);
        lit(0, "t1_err1_resp", F_RESP, 1);
        lit(0, "t1_err1_irq",  F_IRQ,  1);
        lit(0, "t1_fa",        F_FA,   32'h4000_1000);
        lit(0, "t1_fw",        F_FW,   0);
        lit(0, "t1_cnt",       F_CNT,  1);
        @(negedge HCLK);
        lit(0, "t1_err2_rdy",  F_RDY,  1);
        lit(0, "t1_err2_resp", F_RESP, 1);
        lit(0, "t1_err2_irq",  F_IRQ,  0);
        @(negedge HCLK);
        lit(0, "t1_idle_resp", F_RESP, 0);

        // Three wait states then ERROR, write.
        issue(1, 32'h4000_2004, 1'b1);
        lit(1, "t2_w1_rdy",  F_RDY,  0);
        lit(1, "t2_w1_resp", F_RESP, 0);
        lit(1, "t2_fw",      F_FW,   1);
        lit(1, "t2_fa",      F_FA,   32'h4000_2004);
        repeat (2) @(negedge HCLK);
        lit(1, "t2_w3_rdy",  F_RDY,  0);
        lit(1, "t2_w3_resp", F_RESP, 0);
        @(negedge HCLK);
        lit(1, "t2_err1_irq",  F_IRQ,  1);
        lit(1, "t2_err1_resp", F_RESP, 1);
        lit(1, "t2_cnt",       F_CNT,  1);
        @(negedge HCLK);
        lit(1, "t2_done_rdy",  F_RDY,  1);
        lit(1, "t2_done_resp", F_RESP, 1);
        @(negedge HCLK);

        // OKAY/RAZ with two wait states.
        issue(2, 32'h5000_0040, 1'b0);
        lit(2, "t3_w1_rdy", F_RDY, 0);
        @(negedge HCLK);
        lit(2, "t3_w2_rdy", F_RDY, 0);
        @(negedge HCLK);
        lit(2, "t3_done_rdy",  F_RDY,   1);
        lit(2, "t3_done_resp", F_RESP,  0);
        lit(2, "t3_rdata",     F_RDATA, 0);
        lit(2, "t3_irq",       F_IRQ,   0);
        lit(2, "t3_cnt",       F_CNT,   0);
        lit(2, "t3_fa",        F_FA,    0);
        @(negedge HCLK);

        // Zero-wait OKAY mode with no wait states.
        issue(5, 32'h5000_0080, 1'b1);
        lit(5, "t3b_rdy",  F_RDY,  1);
        lit(5, "t3b_resp", F_RESP, 0);

        // Clear, then back-to-back errors with the second accepted in ERR2.
        cnt_clr = 1'b1;
        @(negedge HCLK);
        cnt_clr = 1'b0;
        lit(0, "t4_clr_cnt", F_CNT, 0);
        issue(0, 32'h4000_3000, 1'b0);
        issue(0, 32'h4000_3010, 1'b1);
        lit(0, "t4_b2b_irq", F_IRQ, 1);
        lit(0, "t4_b2b_rdy", F_RDY, 0);
        lit(0, "t4_b2b_cnt", F_CNT, 2);
        lit(0, "t4_b2b_fa",  F_FA,  32'h4000_3010);
        lit(0, "t4_b2b_fw",  F_FW,  1);
        @(negedge HCLK);
        lit(0, "t4_err2_resp", F_RESP, 1);
        @(negedge HCLK);

        // IDLE and BUSY with HSEL high: zero-wait OKAY.
        for (int j = 0; j < 4; j++) begin
            hsel   = 6'b000001;
            htrans = (j < 2) ? 2'b00 : 2'b01;
            haddr  = 32'h4000_4000;
            @(negedge HCLK);
            lit(0, "t4_idlebusy_rdy",  F_RDY,  1);
            lit(0, "t4_idlebusy_resp", F_RESP, 0);
            lit(0, "t4_idlebusy_cnt",  F_CNT,  2);
        end
        hsel   = '0;
        htrans = 2'b00;

        // Two-bit counter saturation, then clear coincident with an error.
        for (int j = 0; j < 4; j++) begin
            issue(3, 32'h6000_0000 + 32'(j * 4), 1'b0);
            repeat (2) @(negedge HCLK);
        end
        lit(3, "t5_sat_cnt", F_CNT, 3);
        cnt_clr = 1'b1;
        issue(3, 32'h6000_0100, 1'b1);
        cnt_clr = 1'b0;
        lit(3, "t5_clr_inc_cnt", F_CNT, 1);
        lit(3, "t5_clr_inc_irq", F_IRQ, 1);
        repeat (2) @(negedge HCLK);

        // Reset asserted during WAIT.
        issue(4, 32'h7000_0000, 1'b0);
        repeat (7) @(negedge HCLK);
        lit(4, "t6_pre_cnt", F_CNT, 1);
        lit(4, "t6_pre_fa",  F_FA,  32'h7000_0000);
        issue(4, 32'h7000_0008, 1'b1);
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        lit(4, "t6_rst_rdy",  F_RDY,  1);
        lit(4, "t6_rst_resp", F_RESP, 0);
        lit(4, "t6_rst_cnt",  F_CNT,  0);
        lit(4, "t6_rst_fa",   F_FA,   0);
        lit(4, "t6_rst_fw",   F_FW,   0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        issue(4, 32'h7000_0010, 1'b0);
        repeat (5) @(negedge HCLK);
        lit(4, "t6_post_irq",  F_IRQ,  1);
        lit(4, "t6_post_resp", F_RESP, 1);
        lit(4, "t6_post_cnt",  F_CNT,  1);
        lit(4, "t6_post_fa",   F_FA,   32'h7000_0010);
        @(negedge HCLK);
        lit(4, "t6_post_done", F_RDY, 1);

        repeat (3) @(negedge HCLK);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
